// File: rtl/soc_now_io_pkg.sv
// Shared constants and helpers for the soc_now_io GPIO bank: register offsets
// within the Wishbone window and a masked-merge function used for byte writes.
package soc_now_io_pkg;

  localparam int unsigned NUM_IO_MAX  = 64;
  localparam int unsigned WB_WIN_BITS = 8;

  localparam logic [WB_WIN_BITS-1:0] OFF_OUT_LO     = 8'h00;
  localparam logic [WB_WIN_BITS-1:0] OFF_OUT_HI     = 8'h04;
  localparam logic [WB_WIN_BITS-1:0] OFF_OEB_LO     = 8'h08;
  localparam logic [WB_WIN_BITS-1:0] OFF_OEB_HI     = 8'h0C;
  localparam logic [WB_WIN_BITS-1:0] OFF_IN_LO      = 8'h10;
  localparam logic [WB_WIN_BITS-1:0] OFF_IN_HI      = 8'h14;
  localparam logic [WB_WIN_BITS-1:0] OFF_RISE_EN_LO = 8'h18;
  localparam logic [WB_WIN_BITS-1:0] OFF_RISE_EN_HI = 8'h1C;
  localparam logic [WB_WIN_BITS-1:0] OFF_FALL_EN_LO = 8'h20;
  localparam logic [WB_WIN_BITS-1:0] OFF_FALL_EN_HI = 8'h24;
  localparam logic [WB_WIN_BITS-1:0] OFF_STAT_LO    = 8'h28;
  localparam logic [WB_WIN_BITS-1:0] OFF_STAT_HI    = 8'h2C;

  // Replace the bits of cur selected by mask with the matching bits of wd.
  function automatic logic [NUM_IO_MAX-1:0] merge64(input logic [NUM_IO_MAX-1:0] cur,
                                                   input logic [NUM_IO_MAX-1:0] wd,
                                                   input logic [NUM_IO_MAX-1:0] mask);
    return (cur & ~mask) | (wd & mask);
  endfunction

endpackage

// File: rtl/soc_now_io_sync.sv
// Two-flop pad-input synchroniser with a previous-value register; emits the
// synchronised value plus single-cycle rise/fall pulses.
module soc_now_io_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/soc_now_io_bank.sv
// Wishbone-slave GPIO bank owning the user pads: OUT/OEB registers, synchronised
// input readback and edge interrupts. `SOC_NOW_IO_LA_OVR_EN adds logic-analyser pad override.
module soc_now_io_bank
  import soc_now_io_pkg::*;
#(
  parameter int unsigned NUM_IO    = 38,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned IRQ_IDX   = 0
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oeb,
  input  logic [NUM_IO-1:0] la_data_in,
  input  logic [NUM_IO-1:0] la_oenb,
  output logic [2:0]        user_irq
);

  logic [NUM_IO-1:0] out_q, out_d;
  logic [NUM_IO-1:0] oeb_q, oeb_d;
  logic [NUM_IO-1:0] rise_en_q, rise_en_d;
  logic [NUM_IO-1:0] fall_en_q, fall_en_d;
  logic [NUM_IO-1:0] stat_q, stat_d;
  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic              irq_q, irq_d;

  logic [NUM_IO-1:0] in_sync, in_rise, in_fall;

  logic [WB_WIN_BITS-1:0] offset;
  logic                   hit, acc, wr;
  logic [31:0]            byte_mask, rd_data;
  logic [63:0]            wdata64, lo_mask, hi_mask;
  logic [63:0]            out_x, oeb_x, in_x, rise_x, fall_x, stat_x;
  logic [63:0]            wm_out, wm_oeb, wm_rise, wm_fall, wm_stat;

  soc_now_io_sync #(.WIDTH(NUM_IO)) u_sync (
    .clk_i  (wb_clk_i),
    .rst_i  (wb_rst_i),
    .d_i    (io_in),
    .sync_o (in_sync),
    .rise_o (in_rise),
    .fall_o (in_fall)
  );

  // Address decode, read mux and per-register write masks.
  always_comb begin
    offset    = wbs_adr_i[WB_WIN_BITS-1:0];
    hit       = (wbs_adr_i[31:WB_WIN_BITS] == BASE_ADDR[31:WB_WIN_BITS]);
    acc       = wbs_cyc_i & wbs_stb_i & ~ack_q & hit;
    wr        = acc & wbs_we_i;
    byte_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    lo_mask   = wr ? {32'h0, byte_mask} : 64'h0;
    hi_mask   = wr ? {byte_mask, 32'h0} : 64'h0;
    wdata64   = {wbs_dat_i, wbs_dat_i};
    out_x     = 64'(out_q);
    oeb_x     = 64'(oeb_q);
    in_x      = 64'(in_sync);
    rise_x    = 64'(rise_en_q);
    fall_x    = 64'(fall_en_q);
    stat_x    = 64'(stat_q);
    wm_out    = 64'h0;
    wm_oeb    = 64'h0;
    wm_rise   = 64'h0;
    wm_fall   = 64'h0;
    wm_stat   = 64'h0;
    rd_data   = 32'h0;
    case (offset)
      OFF_OUT_LO:     begin wm_out  = lo_mask; rd_data = out_x[31:0];   end
      OFF_OUT_HI:     begin wm_out  = hi_mask; rd_data = out_x[63:32];  end
      OFF_OEB_LO:     begin wm_oeb  = lo_mask; rd_data = oeb_x[31:0];   end
      OFF_OEB_HI:     begin wm_oeb  = hi_mask; rd_data = oeb_x[63:32];  end
      OFF_IN_LO:      rd_data = in_x[31:0];
      OFF_IN_HI:      rd_data = in_x[63:32];
      OFF_RISE_EN_LO: begin wm_rise = lo_mask; rd_data = rise_x[31:0];  end
      OFF_RISE_EN_HI: begin wm_rise = hi_mask; rd_data = rise_x[63:32]; end
      OFF_FALL_EN_LO: begin wm_fall = lo_mask; rd_data = fall_x[31:0];  end
      OFF_FALL_EN_HI: begin wm_fall = hi_mask; rd_data = fall_x[63:32]; end
      OFF_STAT_LO:    begin wm_stat = lo_mask; rd_data = stat_x[31:0];  end
      OFF_STAT_HI:    begin wm_stat = hi_mask; rd_data = stat_x[63:32]; end
      default:        ;
    endcase

    out_d     = NUM_IO'(merge64(out_x, wdata64, wm_out));
    oeb_d     = NUM_IO'(merge64(oeb_x, wdata64, wm_oeb));
    rise_en_d = NUM_IO'(merge64(rise_x, wdata64, wm_rise));
    fall_en_d = NUM_IO'(merge64(fall_x, wdata64, wm_fall));
    // New edge events are OR-ed in after the W1C clear so a coincident set wins.
    stat_d    = NUM_IO'(stat_x & ~(wdata64 & wm_stat))
              | (in_rise & rise_en_q) | (in_fall & fall_en_q);
    ack_d     = acc;
    dat_d     = (acc & ~wbs_we_i) ? rd_data : 32'h0;
    irq_d     = |stat_q;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      out_q     <= '0;
      oeb_q     <= '1;
      rise_en_q <= '0;
      fall_en_q <= '0;
      stat_q    <= '0;
      ack_q     <= 1'b0;
      dat_q     <= 32'h0;
      irq_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      oeb_q     <= oeb_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      stat_q    <= stat_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      irq_q     <= irq_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign user_irq  = 3'(irq_q) << IRQ_IDX;

`ifdef SOC_NOW_IO_LA_OVR_EN
  // A pad whose la_oenb bit is low is driven from the logic analyser.
  assign io_out = (out_q & la_oenb) | (la_data_in & ~la_oenb);
  assign io_oeb = oeb_q & la_oenb;
`else
  logic unused_la;
  assign unused_la = ^{la_data_in, la_oenb};
  assign io_out    = out_q;
  assign io_oeb    = oeb_q;
`endif

endmodule

// File: tb/tb_soc_now_io_bank.sv
// Directed self-checking bench for soc_now_io_bank with NUM_IO=38, IRQ_IDX=0.
module tb_soc_now_io_bank;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack_o;
  logic [31:0] dat_o;
  logic [37:0] io_in, io_out, io_oeb, la_data, la_oenb;
  logic [2:0]  irq;

  int total = 0;
  int bad   = 0;

  logic        pre, ack;
  logic [31:0] rd;

  soc_now_io_bank dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (wdat),
    .wbs_ack_o  (ack_o),
    .wbs_dat_o  (dat_o),
    .io_in      (io_in),
    .io_out     (io_out),
    .io_oeb     (io_oeb),
    .la_data_in (la_data),
    .la_oenb    (la_oenb),
    .user_irq   (irq)
  );

  always #5 clk = ~clk;

  // One Wishbone transfer: strobe for one cycle, sample ack/data the cycle after.
  task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] s, output logic pre_ack, output logic got_ack,
                     output logic [31:0] got_dat);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    #1 pre_ack = ack_o;
    @(posedge clk); #1;
    got_ack = ack_o; got_dat = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    total++; if (io_oeb !== {38{1'b1}}) begin bad++; $display("FAIL rst_io_oeb got=%h exp=%h", io_oeb, {38{1'b1}}); end
    total++; if (io_out !== 38'h0) begin bad++; $display("FAIL rst_io_out got=%h exp=0", io_out); end
    total++; if ({ack_o, dat_o, irq} !== 36'h0) begin bad++; $display("FAIL rst_bus_irq got=%h exp=0", {ack_o, dat_o, irq}); end
    @(negedge clk); rst = 1'b0;
    bus(BASE + 32'h08, 1'b0, 32'h0, 4'hF, pre, ack, rd);
    total++; if ({pre, ack} !== 2'b01) begin bad++; $display("FAIL oeb_lo_ack got=%b exp=01", {pre, ack}); end
    total++; if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL oeb_lo_rd got=%h exp=ffffffff", rd); end
    bus(BASE + 32'h0C, 1'b0, 32'h0, 4'hF, pre, ack, rd);
    total++; if ({pre, ack} !== 2'b01) begin bad++; $display("FAIL oeb_hi_ack got=%b exp=01", {pre, ack}); end
    total++; if (rd !== 32'h0000_003F) begin bad++; $display("FAIL oeb_hi_rd got=%h exp=0000003f", rd); end
    bus(BASE + 32'h00, 1'b0, 32'h0, 4'hF, pre, ack, rd);
    total++; if ({ack, rd} !== 33'h1_0000_0000) begin bad++; $display("FAIL out_lo_rd got=%h exp=100000000", {ack, rd}); end
    @(posedge clk); #1;
    total++; if (ack_o !== 1'b0) begin bad++; $display("FAIL ack_single_pulse got=%b exp=0", ack_o); end
  endtask

  task automatic test_byte_write;
    bus(BASE + 32'h00, 1'b1, 32'hA5A5_A5A5, 4'b0011, pre, ack, rd);
    total++; if ({ack, rd} !== 33'h1_0000_0000) begin bad++; $display("FAIL wr_ack_dat got=%h exp=100000000", {ack, rd}); end
    total++; if (io_out[31:0] !== 32'h0000_A5A5) begin bad++; $display("FAIL wr_io_out got=%h exp=0000a5a5", io_out[31:0]); end
    bus(BASE + 32'h00, 1'b0, 32'h0, 4'hF, pre, ack, rd);
    total++; if (rd !== 32'h0000_A5A5) begin bad++; $display("FAIL wr_readback got=%h exp=0000a5a5", rd); end
  endtask

  task automatic test_hi_bits;
    bus(BASE + 32'h04, 1'b1, 32'hFFFF_FFFF, 4'hF, pre, ack, rd);
    total++; if (io_out[37:32] !== 6'h3F) begin bad++; $display("FAIL out_hi_pads got=%h exp=3f", io_out[37:32]); end
    bus(BASE + 32'h04, 1'b0, 32'h0, 4'hF, pre, ack, rd);
    total++; if (rd !== 32'h0000_003F) begin bad++; $display("FAIL out_hi_rd got=%h exp=0000003f", rd); end
    bus(BASE + 32'h08, 1'b1, 32'h0, 4'hF, pre, ack, rd);
    total++; if (io_oeb[31:0] !== 32'h0) begin bad++; $display("FAIL oeb_lo_pads got=%h exp=0", io_oeb[31:0]); end
  endtask

  task automatic test_rise_irq;
    bus(BASE + 32'h18, 1'b1, 32'h0000_0008, 4'hF, pre, ack, rd);
    io_in[3] = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    total++; if (irq !== 3'b000) begin bad++; $display("FAIL rise_irq_early got=%b exp=000", irq); end
    @(posedge clk); #1;
    total++; if (irq !== 3'b001) begin bad++; $display("FAIL rise_irq got=%b exp=001", irq); end
    bus(BASE + 32'h28, 1'b0, 32'h0, 4'hF, pre, ack, rd);
    total++; if (rd !== 32'h0000_0008) begin bad++; $display("FAIL rise_stat got=%h exp=00000008", rd); end
    bus(BASE + 32'h10, 1'b0, 32'h0, 4'hF, pre, ack, rd);
    total++; if (rd !== 32'h0000_0008) begin bad++; $display("FAIL in_lo got=%h exp=00000008", rd); end
    bus(BASE + 32'h28, 1'b1, 32'h0000_0008, 4'hF, pre, ack, rd);
    @(posedge clk); #1;
    total++; if (irq !== 3'b000) begin bad++; $display("FAIL rise_irq_clr got=%b exp=000", irq); end
  endtask

  task automatic test_fall;
    bus(BASE + 32'h20, 1'b1, 32'h0000_0008, 4'hF, pre, ack, rd);
    io_in[3] = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    total++; if (irq !== 3'b001) begin bad++; $display("FAIL fall_irq got=%b exp=001", irq); end
    bus(BASE + 32'h28, 1'b0, 32'h0, 4'hF, pre, ack, rd);
    total++; if (rd !== 32'h0000_0008) begin bad++; $display("FAIL fall_stat got=%h exp=00000008", rd); end
    bus(BASE + 32'h28, 1'b1, 32'h0000_0008, 4'hF, pre, ack, rd);
    repeat (2) begin @(posedge clk); #1; end
    bus(BASE + 32'h28, 1'b0, 32'h0, 4'hF, pre, ack, rd);
    total++; if ({irq, rd} !== 35'h0) begin bad++; $display("FAIL fall_clr got=%h exp=0", {irq, rd}); end
  endtask

  task automatic test_set_wins;
    io_in[3] = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h28; wdat = 32'h0000_0008; sel = 4'hF;
    @(posedge clk); #1;
    ack = ack_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL setwin_ack got=%b exp=1", ack); end
    bus(BASE + 32'h28, 1'b0, 32'h0, 4'hF, pre, ack, rd);
    total++; if (rd !== 32'h0000_0008) begin bad++; $display("FAIL setwin_stat got=%h exp=00000008", rd); end
    bus(BASE + 32'h28, 1'b1, 32'h0000_0008, 4'hF, pre, ack, rd);
    bus(BASE + 32'h28, 1'b0, 32'h0, 4'hF, pre, ack, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL setwin_clr got=%h exp=0", rd); end
  endtask

  task automatic test_unmapped;
    bus(BASE + 32'h3C, 1'b0, 32'h0, 4'hF, pre, ack, rd);
    total++; if ({ack, rd} !== 33'h1_0000_0000) begin bad++; $display("FAIL unmapped_rd got=%h exp=100000000", {ack, rd}); end
    bus(BASE + 32'h100, 1'b1, 32'hFFFF_FFFF, 4'hF, pre, ack, rd);
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL outside_ack got=%b exp=0", ack); end
    @(posedge clk); #1;
    total++; if (ack_o !== 1'b0) begin bad++; $display("FAIL outside_ack_late got=%b exp=0", ack_o); end
    bus(BASE + 32'h10, 1'b1, 32'hFFFF_FFFF, 4'hF, pre, ack, rd);
    bus(BASE + 32'h10, 1'b0, 32'h0, 4'hF, pre, ack, rd);
    total++; if (rd !== 32'h0000_0008) begin bad++; $display("FAIL in_wr_ignored got=%h exp=00000008", rd); end
    bus(BASE + 32'h00, 1'b0, 32'h0, 4'hF, pre, ack, rd);
    total++; if (rd !== 32'h0000_A5A5) begin bad++; $display("FAIL outside_no_change got=%h exp=0000a5a5", rd); end
  endtask

  task automatic test_back_to_back;
    logic [3:0]  pat;
    logic [31:0] d3;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h00; sel = 4'hF;
    for (int i = 3; i >= 0; i--) begin
      @(posedge clk); #1;
      pat[i] = ack_o;
      if (i == 1) d3 = dat_o;
    end
    cyc = 1'b0; stb = 1'b0;
    total++; if (pat !== 4'b1010) begin bad++; $display("FAIL b2b_ack_pattern got=%b exp=1010", pat); end
    total++; if (d3 !== 32'h0000_A5A5) begin bad++; $display("FAIL b2b_second_dat got=%h exp=0000a5a5", d3); end
  endtask

  task automatic test_la;
    bus(BASE + 32'h00, 1'b1, 32'h0, 4'hF, pre, ack, rd);
    bus(BASE + 32'h08, 1'b1, 32'hFFFF_FFFF, 4'hF, pre, ack, rd);
    la_oenb[5] = 1'b0; la_data[5] = 1'b1;
    #1;
`ifdef SOC_NOW_IO_LA_OVR_EN
    total++; if ({io_out[5], io_oeb[5]} !== 2'b10) begin bad++; $display("FAIL la_pad5 got=%b exp=10", {io_out[5], io_oeb[5]}); end
`else
    total++; if ({io_out[5], io_oeb[5]} !== 2'b01) begin bad++; $display("FAIL la_pad5 got=%b exp=01", {io_out[5], io_oeb[5]}); end
`endif
    bus(BASE + 32'h00, 1'b0, 32'h0, 4'hF, pre, ack, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL la_out_rd got=%h exp=0", rd); end
    la_oenb = '1; la_data = '0;
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h00; wdat = 32'h0000_1234; sel = 4'hF;
    #1 rst = 1'b1;
    @(posedge clk); #1;
    total++; if (ack_o !== 1'b0) begin bad++; $display("FAIL midrst_ack got=%b exp=0", ack_o); end
    total++; if ({io_out, io_oeb} !== {38'h0, {38{1'b1}}}) begin bad++; $display("FAIL midrst_pads got=%h exp=%h", {io_out, io_oeb}, {38'h0, {38{1'b1}}}); end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk); rst = 1'b0;
    bus(BASE + 32'h0C, 1'b0, 32'h0, 4'hF, pre, ack, rd);
    total++; if ({pre, ack, rd} !== {2'b01, 32'h0000_003F}) begin bad++; $display("FAIL midrst_after got=%h exp=10000003f", {pre, ack, rd}); end
    bus(BASE + 32'h04, 1'b0, 32'h0, 4'hF, pre, ack, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL midrst_out_hi got=%h exp=0", rd); end
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; wdat = 32'h0;
    io_in = '0; la_data = '0; la_oenb = '1;
    test_reset;
    test_byte_write;
    test_hi_bits;
    test_rise_irq;
    test_fall;
    test_set_wins;
    test_unmapped;
    test_back_to_back;
    test_la;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/soc_now_io_bank.md
Name: soc_now_io_bank

Overview:
- Parametrised Wishbone-slave GPIO bank in the user project area; owns the user pads (io_out/io_oeb/io_in) and raises user interrupts.
- Generalises the fixed 38-pad pass-through: configurable pad count up to 64, per-pad output and output-enable registers, synchronised input readback, and per-pad rising/falling-edge interrupts.
- Sits between the Caravel Wishbone bus and the pad ring.

Parameters:
- NUM_IO, 38, number of pads handled; legal range 1..64.
- BASE_ADDR, 32'h3000_0000, Wishbone base address; the block decodes wbs_adr_i[31:8] == BASE_ADDR[31:8].
- IRQ_IDX, 0, index of the user_irq bit driven by this block; legal range 0..2.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- io_in  in  NUM_IO  pad inputs; asynchronous to wb_clk_i.
- io_out  out  NUM_IO  pad output values.
- io_oeb  out  NUM_IO  pad output-enable, active-low.
- la_data_in  in  NUM_IO  logic-analyser data (used only with the optional feature).
- la_oenb  in  NUM_IO  logic-analyser enable, active-low (used only with the optional feature).
- user_irq  out  3  interrupts; bit IRQ_IDX is driven by this block, other bits are tied 0.

Behaviour:
- Reset (async, wb_rst_i=1): OUT=0, OEB=all 1s, RISE_EN=0, FALL_EN=0, STAT=0, synchroniser flops=0, wbs_ack_o=0, wbs_dat_o=0, user_irq=0.
- Register map, offsets from BASE_ADDR. Each register is split into LO (bits 31:0) and HI (bits 63:32).
  - 0x00/0x04 OUT, RW.
  - 0x08/0x0C OEB, RW.
  - 0x10/0x14 IN, RO; returns the synchronised value.
  - 0x18/0x1C RISE_EN, RW.
  - 0x20/0x24 FALL_EN, RW.
  - 0x28/0x2C STAT, W1C.
- Bits at or above NUM_IO read 0 and ignore writes.
- Handshake:
  - A request is accepted when cyc & stb & ~ack.
  - wbs_ack_o is registered and asserts exactly 1 cycle after acceptance, as a single-cycle pulse.
  - wbs_dat_o is valid in the ack cycle and is 0 otherwise.
  - Back-to-back requests therefore take 2 cycles each.
  - A request dropped (cyc or stb falls) before ack still completes internally; the ack is emitted regardless.
- Writes: apply in the acceptance cycle, per byte under wbs_sel_i. A write to IN is ignored.
- Unmapped offset inside the 256-byte window: ack is returned, read data is 0, writes are ignored. Addresses outside the window: no ack.
- Input path: io_in passes through a 2-flop synchroniser, giving 2-cycle latency to IN.
  - A rising edge is sync=1 with prev=0; a falling edge is sync=0 with prev=1.
- STAT[i] sets when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
- W1C: writing 1 to STAT[i] clears it. If a set and a clear hit the same bit in the same cycle, set wins.
- user_irq[IRQ_IDX] = registered OR of STAT; it asserts 1 cycle after the STAT bit sets.
- Outputs: io_out = OUT and io_oeb = OEB, combinationally from the registers; a write is visible on the pads the cycle after acceptance.
- Reset asserted mid-transaction: ack is suppressed and everything returns to reset values. The first request after reset release behaves normally.

Optional Feature:
- Macro: SOC_NOW_IO_LA_OVR_EN.
- Defined: for each pad i with la_oenb[i]=0, io_out[i]=la_data_in[i] and io_oeb[i]=0. The registers are unaffected and still read back their programmed values.
- Undefined: la_data_in and la_oenb are ignored; the ports remain present so the wrapper netlist is unchanged.

Decomposition:
- Package soc_now_io_pkg holds:
  - register offset localparams (OFF_OUT_LO … OFF_STAT_HI);
  - NUM_IO_MAX=64;
  - WB_WIN_BITS=8.
- Sub-module soc_now_io_sync (param WIDTH): 2-flop synchroniser plus previous-value register; outputs sync, rise and fall vectors.

Test Plan:
- Reset then read OEB_LO and OEB_HI -> 0xFFFF_FFFF and 0x0000_003F (NUM_IO=38); OUT_LO reads 0; each ack is exactly 1 cycle after stb.
- Write OUT_LO=0xA5A5_A5A5 with sel=4'b0011 -> readback 0x0000_A5A5; io_out[15:0]=0xA5A5 on the cycle after acceptance.
- Set RISE_EN_LO bit 3, drive io_in[3] 0->1 -> STAT_LO=0x8 after 3 cycles and user_irq[0]=1 one cycle later; write STAT_LO=0x8 -> irq clears.
- Hold a W1C of STAT bit 3 in the same cycle as a new rising edge on pad 3 -> bit 3 remains 1.
- Read offset 0x3C -> ack with data 0; write to address BASE_ADDR+0x100 -> no ack, no register change.
- With SOC_NOW_IO_LA_OVR_EN: la_oenb[5]=0, la_data_in[5]=1, OUT[5]=0, OEB[5]=1 -> io_out[5]=1 and io_oeb[5]=0; OUT_LO still reads 0.
